// File: rtl/ex_mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier in the EX stage.
package ex_mul_pkg;

   localparam int XLEN              = 32;
   localparam int ITER_BITS_DEFAULT = 1;
   localparam int MUL_ITERS         = XLEN / ITER_BITS_DEFAULT;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mul_state_e;

   function automatic int mul_iters(input int iter_bits);
      return XLEN / iter_bits;
   endfunction

   // Two's-complement magnitude of a value whose sign bit is being honoured.
   function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/ex_mul_unit_if.sv
// EX-stage multiplier bundle: pipeline side is master, multiplier unit is slave.
interface ex_mul_unit_if;
   import ex_mul_pkg::*;

   logic            flush;
   logic            ID_EX_is_mul;
   logic [2:0]      ID_EX_funct3;
   logic [XLEN-1:0] RS1_Data;
   logic [XLEN-1:0] RS2_Data;
   logic            mul_finish;
   logic            mul_busy;
   logic [XLEN-1:0] mul_result;

   modport master (
      output flush, ID_EX_is_mul, ID_EX_funct3, RS1_Data, RS2_Data,
      input  mul_finish, mul_busy, mul_result
   );

   modport slave (
      input  flush, ID_EX_is_mul, ID_EX_funct3, RS1_Data, RS2_Data,
      output mul_finish, mul_busy, mul_result
   );

endinterface

// File: rtl/mul_shift_add_core.sv
// Unsigned shift-add datapath: 64-bit accumulator, retiring ITER_BITS multiplier bits per step.
// MUL_EARLY_OUT_EN enables the early_done flag when the remaining multiplier bits are zero.
module mul_shift_add_core
   import ex_mul_pkg::*;
#(
   parameter int ITER_BITS = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              step,
   input  logic [XLEN-1:0]   mcand_in,
   input  logic [XLEN-1:0]   mplier_in,
   output logic [2*XLEN-1:0] acc_next,
   output logic              early_done
);

   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;

   // acc_next is the accumulator after this step, so the top can capture the final product on the last step.
   always_comb begin
      acc_next = acc;
      for (int k = 0; k < ITER_BITS; k++) begin
         if (mplier[k]) begin
            acc_next = acc_next + (mcand << k);
         end
      end
   end

`ifdef MUL_EARLY_OUT_EN
   assign early_done = ((mplier >> ITER_BITS) == '0);
`else
   assign early_done = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (clear) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{XLEN{1'b0}}, mcand_in};
         mplier <= mplier_in;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << ITER_BITS;
         mplier <= mplier >> ITER_BITS;
      end
   end

endmodule

// File: rtl/ex_mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) that stalls the pipeline until its result is ready.
// Optional MUL_EARLY_OUT_EN ends BUSY as soon as the remaining multiplier bits are zero.
module ex_mul_unit
   import ex_mul_pkg::*;
#(
   parameter int ITER_BITS = 1
)
(
   input  logic        clk,
   input  logic        rst,
   ex_mul_unit_if.slave bus
);

   localparam int ITERS = mul_iters(ITER_BITS);
   localparam int CW    = $clog2(ITERS);
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   mul_state_e        state;
   logic [CW-1:0]     count;
   mul_op_e           op_q;
   logic              prod_neg;
   logic [XLEN-1:0]   mul_result_q;
   logic              busy_q;

   mul_op_e           op_in;
   logic              sign_a;
   logic              sign_b;
   logic              accept;
   logic              last_step;
   logic              early_done;
   logic [2*XLEN-1:0] acc_next;
   logic [2*XLEN-1:0] signed_prod;
   logic [XLEN-1:0]   result_sel;

   assign op_in  = mul_op_e'(bus.ID_EX_funct3[1:0]);
   assign sign_a = bus.RS1_Data[XLEN-1] && (op_in == MULH || op_in == MULHSU);
   assign sign_b = bus.RS2_Data[XLEN-1] && (op_in == MULH);
   assign accept = (state == IDLE) && bus.ID_EX_is_mul && !bus.flush;

   assign last_step = (state == BUSY) && ((count == LAST) || early_done);

   assign signed_prod = prod_neg ? (~acc_next + 64'd1) : acc_next;
   assign result_sel  = (op_q == MUL) ? signed_prod[XLEN-1:0] : signed_prod[2*XLEN-1:XLEN];

   mul_shift_add_core #(.ITER_BITS(ITER_BITS)) u_core (
      .clk        (clk),
      .rst        (rst),
      .clear      (bus.flush),
      .load       (accept),
      .step       (state == BUSY),
      .mcand_in   (abs_if(bus.RS1_Data, sign_a)),
      .mplier_in  (abs_if(bus.RS2_Data, sign_b)),
      .acc_next   (acc_next),
      .early_done (early_done)
   );

   // The result is captured on the final BUSY edge so it is stable for the whole DONE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         count        <= '0;
         op_q         <= MUL;
         prod_neg     <= 1'b0;
         mul_result_q <= '0;
         busy_q       <= 1'b0;
      end else if (bus.flush) begin
         state  <= IDLE;
         count  <= '0;
         busy_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.ID_EX_is_mul) begin
                  state    <= BUSY;
                  count    <= '0;
                  op_q     <= op_in;
                  prod_neg <= sign_a ^ sign_b;
                  busy_q   <= 1'b1;
               end
            end
            BUSY: begin
               if (last_step) begin
                  state        <= DONE;
                  busy_q       <= 1'b0;
                  mul_result_q <= result_sel;
               end else begin
                  count <= count + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               count <= '0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mul_finish = bus.flush ||
                           !(((state == IDLE) && bus.ID_EX_is_mul) || (state == BUSY));
   assign bus.mul_busy   = busy_q;
   assign bus.mul_result = mul_result_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: directed table, corner sequences and randomized ops vs. an arithmetic model.
module tb_ex_mul_unit;
   import ex_mul_pkg::*;

   localparam int TB_ITER_BITS = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_mul_unit_if bus();

   ex_mul_unit #(.ITER_BITS(TB_ITER_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int compared   = 0;
   int mismatched = 0;
   int donePulses = 0;
   logic [31:0] lastExpected = '0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   vec_t vecs [12];

   // Counts cycles in which a multiply in ID/EX is released to EX/MEM.
   always @(negedge clk) begin
      if (rst && bus.ID_EX_is_mul && bus.mul_finish && !bus.flush) donePulses++;
   end

   function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, p;
      xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int refBusyCycles(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
      logic [31:0] m;
      int len;
      m   = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
      len = 0;
      for (int i = 0; i < 32; i++) if (m[i]) len = i + 1;
      return (len < 1) ? 1 : len;
`else
      return 32 / TB_ITER_BITS;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic isMul, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic fl);
      bus.ID_EX_is_mul = isMul;
      bus.ID_EX_funct3 = f3;
      bus.RS1_Data     = a;
      bus.RS2_Data     = b;
      bus.flush        = fl;
   endtask

   // Issues one multiply held in ID/EX until it completes; called just after a rising edge.
   task automatic runMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic endIdle);
      int n;
      logic busyOk;
      applyStimulus(1'b1, {1'b0, op}, a, b, 1'b0);
      #1;
      checkOutput("accept_finish", {63'b0, bus.mul_finish}, 64'd0);
      n = 0;
      busyOk = 1'b1;
      while (n <= 40) begin
         @(posedge clk); #1;
         if (bus.mul_finish) break;
         n++;
         if (!bus.mul_busy) busyOk = 1'b0;
         bus.RS1_Data = $urandom;
         bus.RS2_Data = $urandom;
      end
      checkOutput("busy_cycles", 64'(n), 64'(refBusyCycles(op, b)));
      checkOutput("busy_flag", {63'b0, busyOk}, 64'd1);
      checkOutput("done_busy_low", {63'b0, bus.mul_busy}, 64'd0);
      checkOutput("result", {32'b0, bus.mul_result}, {32'b0, expRes});
      lastExpected = expRes;
      @(posedge clk); #1;
      if (endIdle) begin
         bus.ID_EX_is_mul = 1'b0;
         #1;
         checkOutput("no_restart_finish", {63'b0, bus.mul_finish}, 64'd1);
         checkOutput("no_restart_busy", {63'b0, bus.mul_busy}, 64'd0);
      end
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;

      vecs[0]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
      vecs[1]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[2]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[3]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
      vecs[4]  = '{2'b00, 32'h00000000, 32'hDEADBEEF, 32'h00000000};
      vecs[5]  = '{2'b00, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
      vecs[6]  = '{2'b00, 32'h12345678, 32'h00000001, 32'h12345678};
      vecs[7]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vecs[8]  = '{2'b11, 32'h80000000, 32'h00000002, 32'h00000001};
      vecs[9]  = '{2'b01, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000};
      vecs[10] = '{2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
      vecs[11] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};

      rst = 1'b0;
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
      #1;
      checkOutput("reset_busy", {63'b0, bus.mul_busy}, 64'd0);
      checkOutput("reset_result", {32'b0, bus.mul_result}, 64'd0);
      checkOutput("reset_finish", {63'b0, bus.mul_finish}, 64'd1);
      #12 rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         runMul(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 1'b1);
      end

      // Non-multiply stream never stalls.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
         #1;
         checkOutput("nonmul_finish", {63'b0, bus.mul_finish}, 64'd1);
         checkOutput("nonmul_busy", {63'b0, bus.mul_busy}, 64'd0);
         @(posedge clk); #1;
      end

      // Back-to-back multiplies held in ID/EX across the stall.
      donePulses = 0;
      runMul(2'b00, 32'd3, 32'd4, 32'd12, 1'b0);
      runMul(2'b00, 32'd5, 32'd6, 32'd30, 1'b1);
      checkOutput("b2b_done_pulses", 64'(donePulses), 64'd2);

      // Flush at BUSY count 10.
      applyStimulus(1'b1, 3'b000, 32'h00001234, 32'h0000FFFF, 1'b0);
      #1;
      repeat (11) begin @(posedge clk); #1; end
      checkOutput("flush_pre_busy", {63'b0, bus.mul_busy}, 64'd1);
      bus.flush = 1'b1;
      #1;
      checkOutput("flush_finish", {63'b0, bus.mul_finish}, 64'd1);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.ID_EX_is_mul = 1'b0;
      #1;
      checkOutput("flush_idle_finish", {63'b0, bus.mul_finish}, 64'd1);
      checkOutput("flush_idle_busy", {63'b0, bus.mul_busy}, 64'd0);
      checkOutput("flush_keep_result", {32'b0, bus.mul_result}, {32'b0, lastExpected});
      runMul(2'b00, 32'd2, 32'd2, 32'd4, 1'b1);

      // Asynchronous reset at BUSY count 5.
      applyStimulus(1'b1, 3'b000, 32'h0000ABCD, 32'h0000FFFF, 1'b0);
      #1;
      repeat (6) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      checkOutput("rst_mid_busy", {63'b0, bus.mul_busy}, 64'd0);
      checkOutput("rst_mid_result", {32'b0, bus.mul_result}, 64'd0);
      bus.ID_EX_is_mul = 1'b0;
      #1;
      checkOutput("rst_mid_finish", {63'b0, bus.mul_finish}, 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      runMul(2'b01, 32'hFFFFFFF9, 32'h00000006, refMul(2'b01, 32'hFFFFFFF9, 32'h00000006), 1'b1);

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0:       a = 32'h80000000;
            1:       a = 32'hFFFFFFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       b = 32'($urandom_range(0, 15));
            1:       b = 32'h80000000;
            default: b = $urandom;
         endcase
         runMul(op, a, b, refMul(op, a, b), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ex_mul_unit.md
Name: ex_mul_unit

Overview:
- Iterative RV32M multiplier in the EX stage.
- Drives `mul_finish` to the EX/MEM pipeline register, which captures only while `mul_finish`=1.
- Result `mul_result` is muxed into the EX `ALU_result` path by the EX stage.
- Stalls the pipeline for the duration of MUL/MULH/MULHSU/MULHU; non-multiply instructions pass with `mul_finish`=1 and no stall.

Parameters:
- ITER_BITS, 1, multiplier bits retired per BUSY cycle; legal values 1 or 2; BUSY length = 32/ITER_BITS cycles.
- XLEN, 32, operand width; fixed at 32, not overridable in practice.

Ports:
- clk  input  1  single clock
- rst  input  1  reset; asynchronous and active-low
- flush  input  1  kill the in-flight instruction (branch/jump redirect); priority over everything else
- ID_EX_is_mul  input  1  ID/EX holds an RV32M multiply (opcode 0110011, funct7 0000001, funct3[2]=0)
- ID_EX_funct3  input  3  [1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- RS1_Data  input  32  forwarded rs1 value
- RS2_Data  input  32  forwarded rs2 value
- mul_finish  output  1  1 = EX result ready / no stall; 0 = stall IF/ID/EX and hold EX/MEM
- mul_busy  output  1  1 while in BUSY (debug/perf)
- mul_result  output  32  selected 32-bit half of the product; valid when state=DONE

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=0, async): state=IDLE, count=0, product/accumulator=0, mul_result=0, mul_busy=0. `mul_finish` evaluates to 1 unless ID_EX_is_mul=1.
- IDLE:
  - If ID_EX_is_mul=1 and flush=0: latch operands and op; go to BUSY; mul_finish=0 this cycle.
  - Otherwise stay in IDLE with mul_finish=1.
- Operand prep at latch time:
  - sign_a = rs1[31] for MULH/MULHSU; sign_b = rs2[31] for MULH.
  - Magnitudes are the two's-complement negation of the operand where its sign bit is set.
  - Product sign = sign_a XOR sign_b.
- BUSY:
  - Shift-add over a 64-bit accumulator; ITER_BITS multiplier bits per cycle.
  - count increments from 0 to 32/ITER_BITS-1; at the terminal count go to DONE.
  - mul_finish=0, mul_busy=1.
- DONE:
  - Apply the sign: 64-bit negate if the product sign is set.
  - mul_result = low 32 bits for MUL, high 32 bits otherwise. Registered, so it is stable for the whole DONE cycle.
  - mul_finish=1; unconditionally return to IDLE next cycle. ID_EX_is_mul, still high in DONE, must not restart the unit.
- Latency (ITER_BITS=1): accept at cycle T; BUSY T+1..T+32; DONE at T+33 with mul_finish=1; EX/MEM captures at the end of T+33.
  - ITER_BITS=2: DONE at T+17.
- Back-to-back multiplies: a second MUL enters ID/EX at T+34, is seen in IDLE, and starts a new operation. No lost or duplicated instruction.
- mul_finish is combinational: 1 when flush=1; else 0 when (state=IDLE and ID_EX_is_mul) or state=BUSY; else 1.
- flush in any state: next state IDLE, count cleared; mul_result keeps its previous value.
- Reset mid-BUSY: immediate return to IDLE, all registers cleared.
- Operand changes in ID/EX during BUSY (forwarding updates) are ignored; only the latched values are used.
- Corner products:
  - MULH 0x80000000*0x80000000 → 0x40000000.
  - MUL with either operand 0 → 0.

Optional Feature:
- MUL_EARLY_OUT_EN
  - Defined: in BUSY, if the remaining unshifted multiplier bits are all zero, go to DONE next cycle. Minimum latency is accept + 1 BUSY + DONE; results are identical.
  - Undefined: fixed 32/ITER_BITS BUSY cycles. mul_busy and the latency counters are deterministic.

Decomposition:
- Package ex_mul_pkg:
  - typedef enum logic [1:0] mul_op_e {MUL, MULH, MULHSU, MULHU}
  - typedef enum mul_state_e {IDLE, BUSY, DONE}
  - localparam XLEN=32 and localparam MUL_ITERS=32/ITER_BITS
- One sub-module: mul_shift_add_core (64-bit accumulator, multiplier shift register, ITER_BITS-wide add step).
- The FSM, sign handling and result select stay in ex_mul_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), ITER_BITS=1 → mul_finish low for cycles T..T+32, high at T+33; mul_result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF. MULH 0x80000000*0x80000000 → 0x40000000.
- Back-to-back MUL 3*4 then MUL 5*6 with ID_EX held during stalls → results 12 then 30; exactly two DONE pulses; no restart in DONE.
- Non-mul stream (ID_EX_is_mul=0) → mul_finish=1 every cycle; state stays IDLE.
- flush at BUSY count=10 → next cycle IDLE, mul_finish=1 during the flush cycle; a following MUL 2*2 yields 4 with full latency. Async rst low at count=5 → outputs at reset values immediately.
- With MUL_EARLY_OUT_EN: MUL 0x12345678*1 → DONE after 1 BUSY cycle, result 0x12345678. Without it: 32 BUSY cycles, same result.
